// File: rtl/color_manager_assign_data_if.sv
`default_nettype none
// ============================================================================
// Module   : color_manager_assign_data_if
// Brief    : Valid/ready register-write bus into the colour manager.
// Revision : 1.0 - initial release
// ============================================================================
interface color_manager_assign_data_if #(
  parameter int C_ADDR_WIDTH = 12,
  parameter int C_DATA_WIDTH = 14
);
  logic [C_ADDR_WIDTH-1:0] C_Addr;
  logic [C_DATA_WIDTH-1:0] C_Data;
  logic                    C_Valid;
  logic                    C_Rdy;

  modport master (output C_Addr, output C_Data, output C_Valid, input  C_Rdy);
  modport slave  (input  C_Addr, input  C_Data, input  C_Valid, output C_Rdy);
endinterface
`default_nettype wire

// File: rtl/color_manager_assign_data.sv
`default_nettype none
// ============================================================================
// Module   : color_manager_assign_data
// Brief    : Colour/porch register file and per-region pixel colour selector.
//            Macro COLOR_MANAGER_DEBUG_PATTERN_EN adds an 8-bar test pattern.
// Revision : 1.0 - initial release
// ============================================================================
module color_manager_assign_data #(
  parameter int C_ADDR_WIDTH           = 12,
  parameter int C_DATA_WIDTH           = 14,
  parameter int COUNTER_WIDTH          = 10,
  parameter int DATA_WIDTH             = 12,
  parameter int VGA_NOTIFICATION_WIDTH = 2,
  parameter int BACKPORCH_WIDTH        = 8,
  parameter int FRONTPORCH_WIDTH       = 8,
  parameter int H_ACTIVE               = 640,
  parameter int V_ACTIVE               = 480,
  parameter int ADDR_BASE              = 1000
) (
  input  wire                              Clk,
  input  wire                              Rst,
  color_manager_assign_data_if.slave       ctrl,
  input  wire                              Vertical_Split,
  input  wire                              Horizontal_Split,
  input  wire                              VGA_Debugg,
  input  wire                              Counter_X_Valid,
  input  wire [COUNTER_WIDTH-1:0]          Counter_X,
  input  wire                              Counter_Y_Valid,
  input  wire [COUNTER_WIDTH-1:0]          Counter_Y,
  output logic [VGA_NOTIFICATION_WIDTH-1:0] VGA_Notification,
  output logic                             VGA_Notification_Valid,
  output logic [DATA_WIDTH-1:0]            Data_VGA,
  output logic [BACKPORCH_WIDTH-1:0]       H_BackPorch,
  output logic [FRONTPORCH_WIDTH-1:0]      H_FrontPorch,
  output logic [BACKPORCH_WIDTH-1:0]       V_BackPorch,
  output logic [FRONTPORCH_WIDTH-1:0]      V_FrontPorch
);

  localparam logic [C_ADDR_WIDTH-1:0]  c_addr_colour = C_ADDR_WIDTH'(ADDR_BASE);
  localparam logic [C_ADDR_WIDTH-1:0]  c_addr_hbp    = C_ADDR_WIDTH'(ADDR_BASE + 1);
  localparam logic [C_ADDR_WIDTH-1:0]  c_addr_hfp    = C_ADDR_WIDTH'(ADDR_BASE + 2);
  localparam logic [C_ADDR_WIDTH-1:0]  c_addr_vbp    = C_ADDR_WIDTH'(ADDR_BASE + 3);
  localparam logic [C_ADDR_WIDTH-1:0]  c_addr_vfp    = C_ADDR_WIDTH'(ADDR_BASE + 4);
  localparam logic [COUNTER_WIDTH-1:0] c_h_active    = COUNTER_WIDTH'(H_ACTIVE);
  localparam logic [COUNTER_WIDTH-1:0] c_v_active    = COUNTER_WIDTH'(V_ACTIVE);
  localparam logic [COUNTER_WIDTH-1:0] c_h_half      = COUNTER_WIDTH'(H_ACTIVE / 2);
  localparam logic [COUNTER_WIDTH-1:0] c_v_half      = COUNTER_WIDTH'(V_ACTIVE / 2);
  localparam logic [VGA_NOTIFICATION_WIDTH-1:0] c_notif_colour = VGA_NOTIFICATION_WIDTH'(1);
  localparam logic [VGA_NOTIFICATION_WIDTH-1:0] c_notif_porch  = VGA_NOTIFICATION_WIDTH'(2);

  // Handshake FSM: INIT holds C_Rdy low until the first clock after reset.
  localparam logic [1:0] c_st_init  = 2'd0;
  localparam logic [1:0] c_st_ready = 2'd1;
  localparam logic [1:0] c_st_hold  = 2'd2;

  logic [1:0] r_state;
  logic [1:0] w_state_next;
  logic       w_rdy;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) r_state <= c_st_init;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_init:  w_state_next = c_st_ready;
      c_st_ready: if (ctrl.C_Valid) w_state_next = c_st_hold;
      c_st_hold:  w_state_next = c_st_ready;
      default:    w_state_next = c_st_init;
    endcase
  end

  always_comb begin
    w_rdy = 1'b0;
    if (r_state == c_st_ready) w_rdy = 1'b1;
  end

  assign ctrl.C_Rdy = w_rdy;

  // Register file
  logic                    w_accept;
  logic [1:0]              w_wr_region;
  logic [DATA_WIDTH-1:0]   r_colour [4];
  logic [VGA_NOTIFICATION_WIDTH-1:0] r_notif;
  logic                    r_notif_valid;
  logic [BACKPORCH_WIDTH-1:0]  r_hbp, r_vbp;
  logic [FRONTPORCH_WIDTH-1:0] r_hfp, r_vfp;

  assign w_accept    = ctrl.C_Valid & w_rdy;
  assign w_wr_region = ctrl.C_Data[C_DATA_WIDTH-1 -: 2];

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < 4; i++) r_colour[i] <= '0;
      r_notif       <= '0;
      r_notif_valid <= 1'b0;
      r_hbp         <= BACKPORCH_WIDTH'(48);
      r_hfp         <= FRONTPORCH_WIDTH'(16);
      r_vbp         <= BACKPORCH_WIDTH'(33);
      r_vfp         <= FRONTPORCH_WIDTH'(10);
    end else begin
      r_notif_valid <= 1'b0;
      if (w_accept) begin
        case (ctrl.C_Addr)
          c_addr_colour: begin
            r_colour[w_wr_region] <= ctrl.C_Data[DATA_WIDTH-1:0];
            r_notif       <= c_notif_colour;
            r_notif_valid <= 1'b1;
          end
          c_addr_hbp: begin
            r_hbp <= ctrl.C_Data[BACKPORCH_WIDTH-1:0];
            r_notif <= c_notif_porch;
            r_notif_valid <= 1'b1;
          end
          c_addr_hfp: begin
            r_hfp <= ctrl.C_Data[FRONTPORCH_WIDTH-1:0];
            r_notif <= c_notif_porch;
            r_notif_valid <= 1'b1;
          end
          c_addr_vbp: begin
            r_vbp <= ctrl.C_Data[BACKPORCH_WIDTH-1:0];
            r_notif <= c_notif_porch;
            r_notif_valid <= 1'b1;
          end
          c_addr_vfp: begin
            r_vfp <= ctrl.C_Data[FRONTPORCH_WIDTH-1:0];
            r_notif <= c_notif_porch;
            r_notif_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Pixel path: the lookup reads the pre-write colour when both land together.
  logic                  w_xr, w_yr, w_active;
  logic [DATA_WIDTH-1:0] w_pixel;
  logic [DATA_WIDTH-1:0] r_data_vga;

  assign w_xr     = Vertical_Split   & (Counter_X >= c_h_half);
  assign w_yr     = Horizontal_Split & (Counter_Y >= c_v_half);
  assign w_active = Counter_X_Valid & Counter_Y_Valid &
                    (Counter_X < c_h_active) & (Counter_Y < c_v_active);

`ifdef COLOR_MANAGER_DEBUG_PATTERN_EN
  logic [DATA_WIDTH-1:0] w_bar;
  always_comb begin
    w_bar = '0;
    case (Counter_X[COUNTER_WIDTH-1 -: 3])
      3'd0: w_bar = DATA_WIDTH'(12'h000);
      3'd1: w_bar = DATA_WIDTH'(12'hF00);
      3'd2: w_bar = DATA_WIDTH'(12'h0F0);
      3'd3: w_bar = DATA_WIDTH'(12'h00F);
      3'd4: w_bar = DATA_WIDTH'(12'hFF0);
      3'd5: w_bar = DATA_WIDTH'(12'h0FF);
      3'd6: w_bar = DATA_WIDTH'(12'hF0F);
      3'd7: w_bar = DATA_WIDTH'(12'hFFF);
      default: w_bar = '0;
    endcase
  end

  always_comb begin
    w_pixel = '0;
    if (w_active) w_pixel = VGA_Debugg ? w_bar : r_colour[{w_yr, w_xr}];
  end
`else
  logic w_unused_debugg;
  assign w_unused_debugg = VGA_Debugg;

  always_comb begin
    w_pixel = '0;
    if (w_active) w_pixel = r_colour[{w_yr, w_xr}];
  end
`endif

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) r_data_vga <= '0;
    else      r_data_vga <= w_pixel;
  end

  assign Data_VGA               = r_data_vga;
  assign VGA_Notification       = r_notif;
  assign VGA_Notification_Valid = r_notif_valid;
  assign H_BackPorch            = r_hbp;
  assign H_FrontPorch           = r_hfp;
  assign V_BackPorch            = r_vbp;
  assign V_FrontPorch           = r_vfp;

endmodule
`default_nettype wire

// File: tb/tb_color_manager_assign_data.sv
`default_nettype none
// ============================================================================
// Module   : tb_color_manager_assign_data
// Brief    : Scoreboard bench: directed plan items followed by random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_color_manager_assign_data;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  always #5 Clk = ~Clk;

  color_manager_assign_data_if #(.C_ADDR_WIDTH(12), .C_DATA_WIDTH(14)) bus ();

  logic       vsplit, hsplit, dbg, xvalid, yvalid;
  logic [9:0] cx, cy;
  logic [1:0] notif;
  logic       notif_valid;
  logic [11:0] data_vga;
  logic [7:0] hbp, hfp, vbp, vfp;

  color_manager_assign_data dut (
    .Clk                    (Clk),
    .Rst                    (Rst),
    .ctrl                   (bus.slave),
    .Vertical_Split         (vsplit),
    .Horizontal_Split       (hsplit),
    .VGA_Debugg             (dbg),
    .Counter_X_Valid        (xvalid),
    .Counter_X              (cx),
    .Counter_Y_Valid        (yvalid),
    .Counter_Y              (cy),
    .VGA_Notification       (notif),
    .VGA_Notification_Valid (notif_valid),
    .Data_VGA               (data_vga),
    .H_BackPorch            (hbp),
    .H_FrontPorch           (hfp),
    .V_BackPorch            (vbp),
    .V_FrontPorch           (vfp)
  );

  typedef struct {
    logic [11:0] data;
    logic        nv;
    logic [1:0]  nc;
    logic        rdy;
    logic [7:0]  hbp, hfp, vbp, vfp;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model state
  logic [11:0] m_col [4];
  logic [7:0]  m_hbp = 8'd48, m_hfp = 8'd16, m_vbp = 8'd33, m_vfp = 8'd10;
  logic [1:0]  m_nc = 2'd0;
  bit          m_rdy = 1'b0;
  logic [11:0] bars [8] = '{12'h000, 12'hF00, 12'h0F0, 12'h00F,
                            12'hFF0, 12'h0FF, 12'hF0F, 12'hFFF};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] model_pixel(input bit xv, input int x, input bit yv,
                                              input int y, input bit vs, input bit hs,
                                              input bit db);
    int region;
    if (!(xv && yv) || x >= 640 || y >= 480) return 12'h000;
`ifdef COLOR_MANAGER_DEBUG_PATTERN_EN
    if (db) return bars[x / 128];
`else
    if (db) region = 0;
`endif
    region = ((vs && x >= 320) ? 1 : 0) + ((hs && y >= 240) ? 2 : 0);
    return m_col[region];
  endfunction

  // Called at a falling edge: drives one cycle and queues what must appear after the next rising edge.
  task automatic step(input int a, input int d, input bit v, input bit xv, input int x,
                      input bit yv, input int y, input bit vs, input bit hs, input bit db);
    exp_t e;
    bit   acc;
    bus.C_Addr = 12'(a); bus.C_Data = 14'(d); bus.C_Valid = v;
    xvalid = xv; cx = 10'(x); yvalid = yv; cy = 10'(y);
    vsplit = vs; hsplit = hs; dbg = db;
    e.data = model_pixel(xv, x, yv, y, vs, hs, db);
    acc = v && m_rdy;
    e.nv = 1'b0;
    if (acc) begin
      e.nv = 1'b1;
      case (a)
        1000: begin m_col[(d >> 12) & 3] = 12'(d & 'hFFF); m_nc = 2'd1; end
        1001: begin m_hbp = 8'(d); m_nc = 2'd2; end
        1002: begin m_hfp = 8'(d); m_nc = 2'd2; end
        1003: begin m_vbp = 8'(d); m_nc = 2'd2; end
        1004: begin m_vfp = 8'(d); m_nc = 2'd2; end
        default: e.nv = 1'b0;
      endcase
    end
    m_rdy = !acc;
    e.nc = m_nc; e.rdy = m_rdy;
    e.hbp = m_hbp; e.hfp = m_hfp; e.vbp = m_vbp; e.vfp = m_vfp;
    exp_q.push_back(e);
    @(negedge Clk);
  endtask

  // Monitor: one queued expectation per rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("data_vga",    data_vga,    e.data);
        check("notif_valid", notif_valid, e.nv);
        check("notif_code",  notif,       e.nc);
        check("c_rdy",       bus.C_Rdy,   e.rdy);
        check("h_backporch", hbp,         e.hbp);
        check("h_frontporch",hfp,         e.hfp);
        check("v_backporch", vbp,         e.vbp);
        check("v_frontporch",vfp,         e.vfp);
      end
    end
  end

  initial begin
    int x, y, a, r;
    for (int i = 0; i < 4; i++) m_col[i] = 12'h000;
    bus.C_Addr = '0; bus.C_Data = '0; bus.C_Valid = 1'b0;
    vsplit = 0; hsplit = 0; dbg = 0; xvalid = 1; yvalid = 1; cx = 10'd5; cy = 10'd5;

    repeat (3) @(negedge Clk);
    check("rst_data_vga",    data_vga,    12'h000);
    check("rst_c_rdy",       bus.C_Rdy,   1'b0);
    check("rst_notif",       notif,       2'd0);
    check("rst_notif_valid", notif_valid, 1'b0);
    check("rst_h_backporch", hbp,         8'd48);
    check("rst_h_frontporch",hfp,         8'd16);
    check("rst_v_backporch", vbp,         8'd33);
    check("rst_v_frontporch",vfp,         8'd10);
    Rst = 1'b1;

    // Colour write to region 0 with counters at (1,1)
    step(0, 0, 0, 1, 1, 1, 1, 0, 0, 0);
    step(1000, 14'b00111111111111, 1, 1, 1, 1, 1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 1, 1, 1, 1, 0, 0, 0);
    // Horizontal split, blanking and lower region
    step(0, 0, 0, 1, 223, 1, 960, 0, 1, 0);
    step(0, 0, 0, 1, 223, 1, 300, 0, 1, 0);
    step(1000, 14'b10111100011111, 1, 1, 223, 1, 300, 0, 1, 0);
    step(0, 0, 0, 1, 223, 1, 300, 0, 1, 0);
    step(0, 0, 0, 1, 223, 1, 100, 0, 1, 0);
    // Region boundaries
    step(0, 0, 0, 1, 319, 1, 239, 1, 1, 0);
    step(0, 0, 0, 1, 320, 1, 240, 1, 1, 0);
    step(0, 0, 0, 1, 639, 1, 479, 1, 1, 0);
    step(0, 0, 0, 1, 640, 1, 100, 1, 1, 0);
    step(0, 0, 0, 0, 100, 1, 100, 0, 0, 0);
    // Porch write, then an unmapped address
    step(1001, 60, 1, 1, 10, 1, 10, 0, 0, 0);
    step(0, 0, 0, 1, 10, 1, 10, 0, 0, 0);
    step(1234, 77, 1, 1, 10, 1, 10, 0, 0, 0);
    step(0, 0, 0, 1, 10, 1, 10, 0, 0, 0);
    // Valid held for four cycles
    repeat (4) step(1004, 25, 1, 1, 10, 1, 10, 0, 0, 0);
    step(0, 0, 0, 1, 10, 1, 10, 0, 0, 0);

    for (int n = 0; n < 2000; n++) begin
      r = int'($urandom_range(0, 7));
      a = (r < 5) ? 1000 + r : int'($urandom_range(0, 4095));
      case ($urandom_range(0, 3))
        0:       x = 319 + int'($urandom_range(0, 1));
        1:       x = 639 + int'($urandom_range(0, 1));
        default: x = int'($urandom_range(0, 1023));
      endcase
      case ($urandom_range(0, 3))
        0:       y = 239 + int'($urandom_range(0, 1));
        1:       y = 479 + int'($urandom_range(0, 1));
        default: y = int'($urandom_range(0, 1023));
      endcase
      step(a, int'($urandom_range(0, 16383)), bit'($urandom_range(0, 1)),
           bit'($urandom_range(0, 7) != 0), x, bit'($urandom_range(0, 7) != 0), y,
           bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
           bit'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge Clk);
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
